// File: rtl/pulse_meter.sv
// Pulse-train receiver: counts rising edges of din over a programmable window
// and hands the saturating count downstream through a valid/ready handshake.
module pulse_meter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] REM_ONE = WIN_W'(1);

  state_e           state_q;
  logic [WIN_W-1:0] rem_q;
  logic             din_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             busy_q;
  logic             valid_q;

  logic edge_seen;
  logic cnt_at_max;

  assign edge_seen  = din & ~din_q;
  assign cnt_at_max = (count_q == CNT_MAX);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours, like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      din_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      din_q <= din;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q      <= win_len;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // A zero-length window skips MEASURE and reports an empty count.
            if (win_len == '0) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_MEASURE;
              busy_q  <= 1'b1;
            end
          end
        end

        S_MEASURE: begin
          if (edge_seen) begin
            if (cnt_at_max) overflow_q <= 1'b1;
            else            count_q    <= count_q + CNT_W'(1);
          end
          rem_q <= rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end

        S_DONE: begin
          if (ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed scenarios with literal
// expectations plus a randomized run against a window-based reference model.
module tb_pulse_meter;

  localparam int CNT_W   = 4;
  localparam int WIN_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_meter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .start    (start),
    .win_len  (win_len),
    .busy     (busy),
    .valid    (valid),
    .ready    (ready),
    .count    (count),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a measurement is a window of absolute cycle numbers
  // [m_ws, m_we]; the result is pending from m_we+1 until a ready cycle.
  bit     m_live   = 1'b0;
  bit     m_active = 1'b0;
  bit     m_prev   = 1'b0;
  longint m_ws     = 0;
  longint m_we     = 0;
  int     m_edges  = 0;
  longint cyc      = 0;

  always @(posedge clk) begin
    bit e;
    if (rst) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
      m_edges  = 0;
      m_live   = 1'b1;
    end else begin
      e      = din & ~m_prev;
      m_prev = din;
      if (m_active && cyc >= m_ws && cyc <= m_we && e) m_edges++;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_ws     = cyc + 1;
          m_we     = cyc + longint'(win_len);
          m_edges  = 0;
        end
      end else if (cyc > m_we && ready) begin
        m_active = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit exp_busy;
    bit exp_valid;
    if (m_live) begin
      exp_busy  = m_active && cyc >= m_ws && cyc <= m_we;
      exp_valid = m_active && cyc > m_we;
      check("model_busy", busy, exp_busy);
      check("model_valid", valid, exp_valid);
      if (exp_valid) begin
        check("model_count", count, (m_edges > CNT_MAX) ? CNT_MAX : m_edges);
        check("model_overflow", overflow, m_edges > CNT_MAX);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int mode, input int i);
    case (mode)
      0:       return logic'(i % 2 == 0);
      1, 2:    return 1'b1;
      3:       return logic'(i % 3 == 0);
      4:       return logic'(i == 2 || i == 5 || i == 8);
      default: return 1'b0;
    endcase
  endfunction

  // One complete measurement: start in cycle T, drive the pattern over the
  // window, then check the result at T+n+1 and the transfer back to IDLE.
  task automatic run(input string name, input int n, input int mode, input logic pre,
                     input bit b2b, input int exp_cnt, input logic exp_ovf);
    if (!b2b) begin
      din = pre; start = 1'b0; ready = 1'b1;
      step();
    end
    start = 1'b1; win_len = WIN_W'(n); din = pre; ready = 1'b1;
    step();
    start = 1'b0;
    win_len = WIN_W'($urandom);
    for (int i = 1; i <= n; i++) begin
      din   = pat(mode, i);
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check({name, "_busy"}, busy, 1);
      step();
    end
    din = pat(mode, n + 1); start = 1'b0; ready = 1'b1;
    @(negedge clk);
    check({name, "_valid"}, valid, 1);
    check({name, "_busy_done"}, busy, 0);
    check({name, "_count"}, count, exp_cnt);
    check({name, "_overflow"}, overflow, exp_ovf);
    step();
    din = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, valid, 0);
  endtask

  initial begin
    // Reset held two cycles with din toggling and start asserted.
    rst = 1'b1; din = 1'b0; start = 1'b1; ready = 1'b0; win_len = 16'd5;
    step();
    din = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    step();
    rst = 1'b0; start = 1'b0; din = 1'b0;
    @(negedge clk);
    check("rst2_busy", busy, 0);
    check("rst2_valid", valid, 0);

    run("basic",     10, 0, 1'b0, 1'b0, 5,  1'b0);
    run("odd_tail",   9, 0, 1'b0, 1'b0, 4,  1'b0);
    run("level",      8, 1, 1'b1, 1'b0, 0,  1'b0);
    run("rise_t1",    8, 2, 1'b0, 1'b0, 1,  1'b0);
    run("sat",       60, 3, 1'b0, 1'b0, 15, 1'b1);
    run("after_sat", 12, 4, 1'b0, 1'b0, 3,  1'b0);
    run("zero",       0, 0, 1'b0, 1'b0, 0,  1'b0);
    run("b2b",        5, 0, 1'b0, 1'b1, 2,  1'b0);

    // Backpressure: result held for 5 cycles, a start pulse meanwhile ignored.
    start = 1'b1; win_len = 16'd4; din = 1'b0; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din = logic'(i % 2 == 0);
      step();
    end
    ready = 1'b0; din = 1'b0;
    for (int j = 0; j < 5; j++) begin
      start = (j == 2); win_len = 16'd1; din = logic'(j % 2);
      @(negedge clk);
      check("bp_valid", valid, 1);
      check("bp_count", count, 2);
      check("bp_busy", busy, 0);
      step();
    end
    start = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("bp_valid_last", valid, 1);
    step();
    @(negedge clk);
    check("bp_released", valid, 0);
    check("bp_no_restart", busy, 0);

    // Reset in the middle of a window discards the measurement.
    start = 1'b1; win_len = 16'd20; din = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = logic'($urandom_range(0, 1));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_count", count, 0);
    for (int i = 0; i < 25; i++) begin
      din = logic'($urandom_range(0, 1));
      @(negedge clk);
      check("mid_rst_no_valid", valid, 0);
      step();
    end

    // Randomized traffic; the model above checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      win_len = ($urandom_range(0, 9) == 0) ? WIN_W'($urandom_range(30, 70))
                                            : WIN_W'($urandom_range(0, 12));
      din     = logic'($urandom_range(0, 1));
      ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; start = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
